mem_access_unit: RTL

- MEM-stage consumer of the 9-bit memory control bus produced by the ID-stage decoder and carried through the ID/EX and EX/MEM registers.
- Turns a load/store into a single-beat req/ack transaction on the data-memory port, with byte-lane enables and store-data replication.
- Returns sign- or zero-extended load data to the MEM/WB register and holds the pipeline stalled while the memory is busy.
- Reports misaligned, conflicting-control and timeout faults.

---
 rtl/mips_ctrl_pkg.sv | 39 +++
 rtl/load_extender.sv | 25 ++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: memory control bus bit positions, fault codes,
// MEM-stage state encoding and access sizes.
package mips_ctrl_pkg;

    localparam int CTRL_SB       = 8;
    localparam int CTRL_SH       = 7;
    localparam int CTRL_LB       = 6;
    localparam int CTRL_LH       = 5;
    localparam int CTRL_UNSIGNED = 4;
    localparam int CTRL_BNEQ     = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_CONFLICT = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    // Byte-lane enables for an access of the given size at byte offset 'lane'.
    function automatic logic [3:0] lane_enable(input mem_size_t size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_enable = 4'b0001 << lane;
            SZ_HALF: lane_enable = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_enable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Load-data lane select and sign/zero extension for byte, half and word reads.
module load_extender
    import mips_ctrl_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] rdata,
    input  logic [1:0]         lane,
    input  mem_size_t          size,
    input  logic               is_unsigned,
    output logic [NB_DATA-1:0] data
);

    logic [NB_DATA-1:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SZ_BYTE: data = {{(NB_DATA-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{(NB_DATA-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: single-beat req/ack load/store with
// byte lanes, load extension, pipeline stall and fault reporting.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no transaction; decode, check and accept a new access
//   ST_BUSY | request outstanding; wait for ack or watchdog expiry
module mem_access_unit
    import mips_ctrl_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 32,
    parameter int NB_CTRL_M      = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [NB_CTRL_M-1:0] i_ctrl_mem_bus,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [NB_DATA-1:0]   i_wr_data,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [NB_ADDR-3:0]   o_mem_addr,
    output logic [3:0]           o_mem_be,
    output logic [NB_DATA-1:0]   o_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [NB_DATA-1:0]   i_mem_rdata,
    output logic [NB_DATA-1:0]   o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_wr_done,
    output logic                 o_stall,
    output logic                 o_fault,
    output logic [1:0]           o_fault_cause
);

    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam int NB_WD = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_WD-1:0] WD_LOAD = NB_WD'(TIMEOUT_CYCLES - 1);

    mem_state_t         state;
    mem_size_t          size_d;
    mem_size_t          size_q;
    logic               uns_q;
    logic [1:0]         lane_q;
    logic [NB_WD-1:0]   wd_cnt;

    logic               is_rd, is_wr, op, conflict, misaligned, accept;
    logic [3:0]         be_d;
    logic [NB_DATA-1:0] wdata_d;
    logic [NB_DATA-1:0] ext_data;

    // Branch/BNEQ belong to the branch unit.
    logic unused_branch_bits;
    assign unused_branch_bits = ^i_ctrl_mem_bus[CTRL_BNEQ:CTRL_BRANCH];

    always_comb begin
        is_rd    = i_ctrl_mem_bus[CTRL_MEMREAD];
        is_wr    = i_ctrl_mem_bus[CTRL_MEMWRITE];
        op       = i_valid & (is_rd | is_wr);
        conflict = (is_rd & is_wr)
                 | (i_ctrl_mem_bus[CTRL_LB] & i_ctrl_mem_bus[CTRL_LH])
                 | (i_ctrl_mem_bus[CTRL_SB] & i_ctrl_mem_bus[CTRL_SH]);
        if (is_wr)
            size_d = i_ctrl_mem_bus[CTRL_SB] ? SZ_BYTE : (i_ctrl_mem_bus[CTRL_SH] ? SZ_HALF : SZ_WORD);
        else
            size_d = i_ctrl_mem_bus[CTRL_LB] ? SZ_BYTE : (i_ctrl_mem_bus[CTRL_LH] ? SZ_HALF : SZ_WORD);
        misaligned = ((size_d == SZ_HALF) && i_addr[0])
                   || ((size_d == SZ_WORD) && (i_addr[1:0] != 2'b00));
        accept     = (state == ST_IDLE) && op && !conflict && !misaligned;
        be_d       = lane_enable(size_d, i_addr[1:0]);
        case (size_d)
            SZ_BYTE: wdata_d = {4{i_wr_data[7:0]}};
            SZ_HALF: wdata_d = {2{i_wr_data[15:0]}};
            default: wdata_d = i_wr_data;
        endcase
    end

    assign o_stall = accept || ((state == ST_BUSY) && !i_mem_ack);

    load_extender #(.NB_DATA(NB_DATA)) u_load_extender (
        .rdata       (i_mem_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ext_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= ST_IDLE;
            size_q        <= SZ_WORD;
            uns_q         <= 1'b0;
            lane_q        <= 2'b00;
            wd_cnt        <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_be      <= 4'b0000;
            o_mem_wdata   <= '0;
            o_rd_data     <= '0;
            o_rd_valid    <= 1'b0;
            o_wr_done     <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_cause <= 2'b00;
        end else begin
            o_rd_valid <= 1'b0;
            o_wr_done  <= 1'b0;
            o_fault    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op) begin
                        if (conflict) begin
                            o_fault       <= 1'b1;
                            o_fault_cause <= FAULT_CONFLICT;
                        end else if (misaligned) begin
                            o_fault       <= 1'b1;
                            o_fault_cause <= FAULT_MISALIGN;
                        end else begin
                            state       <= ST_BUSY;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= is_wr;
                            o_mem_addr  <= i_addr[NB_ADDR-1:2];
                            o_mem_be    <= be_d;
                            o_mem_wdata <= wdata_d;
                            size_q      <= size_d;
                            uns_q       <= i_ctrl_mem_bus[CTRL_UNSIGNED];
                            lane_q      <= i_addr[1:0];
                            wd_cnt      <= WD_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack wins over a watchdog expiry in the same cycle.
                    if (i_mem_ack) begin
                        state     <= ST_IDLE;
                        o_mem_req <= 1'b0;
                        if (o_mem_we) begin
                            o_wr_done <= 1'b1;
                        end else begin
                            o_rd_valid <= 1'b1;
                            o_rd_data  <= ext_data;
                        end
                    end else if (WD_EN && (wd_cnt == '0)) begin
                        state         <= ST_IDLE;
                        o_mem_req     <= 1'b0;
                        o_fault       <= 1'b1;
                        o_fault_cause <= FAULT_TIMEOUT;
                    end else if (WD_EN) begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
